axi4_burst_wr_master: RTL and testbench

- Master-side counterpart to the slave-side AXI4 burst address generator.
- Accepts a write command (word-aligned start address, length in 32-bit words) and streams data from a valid/ready source.
- Splits the transfer into AXI4 INCR write bursts of at most MAX_BURST beats, never crossing a 4 KB boundary.
- Drives the AW, W and B channels of a 32-bit AXI4 master port, with one burst outstanding at a time.

---
 rtl/axi4_burst_wr_master.sv | 201 ++++++++++++++++++++
 tb/tb_axi4_burst_wr_master.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_wr_master.sv
// -----------------------------------------------------------------------------
// axi4_burst_wr_master
//   Takes a write command (word-aligned start address plus a length in 32-bit
//   words), streams the payload from a valid/ready source and issues it as a
//   sequence of AXI4 INCR write bursts. Each burst is at most MAX_BURST beats
//   and never crosses a 4 KB boundary. Only one burst is in flight: the next
//   AW is issued after the previous B response has been taken.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_addr (bits [1:0] dropped),
//                         cmd_len in words
//   s_data/s_valid/s_ready  payload source, passed straight through to W
//   aw*                   AXI4 write address channel (size 4 B, INCR)
//   w*                    AXI4 write data channel (wdata = s_data, all strobes)
//   bresp/bvalid/bready   AXI4 write response channel
//   busy                  high while a command is being worked on
//   done                  one-cycle pulse when the whole command has completed
//   err                   (only with AXI4_WR_BRESP_CHK_EN) sticky flag, set by
//                         any non-OKAY write response, cleared on reset and on
//                         command accept
//
// Build option
//   AXI4_WR_BRESP_CHK_EN  adds the err output; otherwise bresp is ignored.
// -----------------------------------------------------------------------------
module axi4_burst_wr_master #(
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        busy,
  output logic        done
`ifdef AXI4_WR_BRESP_CHK_EN
  ,
  output logic        err
`endif
);

  // state  | meaning
  // -------+-----------------------------------------------------------
  // S_IDLE | waiting for a command, cmd_ready high
  // S_AW   | presenting burst address/length, waiting for awready
  // S_W    | passing source beats to W until the wlast handshake
  // S_B    | waiting for the write response of the current burst
  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  localparam logic [16:0] MAX_B17 = 17'(MAX_BURST);

  state_t      state, state_nx;
  logic [31:0] addr_q;
  logic [7:0]  awlen_q;
  logic [15:0] rem_q;
  logic [7:0]  beat_q;
  logic        done_q;
  logic        last_beat;
  logic [8:0]  beats;
  logic        unused_bits;

  // Beats in the next burst, returned as awlen (beats-1). Worked in 17 bits so
  // the words-to-boundary term (up to 1024) and MAX_BURST=256 do not wrap.
  function automatic logic [7:0] burst_awlen(input logic [11:0] offs,
                                             input logic [15:0] rem);
    logic [16:0] room;
    logic [16:0] n;
    room = (17'd4096 - {5'd0, offs}) >> 2;
    n    = {1'b0, rem};
    if (n > MAX_B17) n = MAX_B17;
    if (n > room)    n = room;
    burst_awlen = 8'(n - 17'd1);
  endfunction

  assign last_beat = (beat_q == awlen_q);
  assign beats     = {1'b0, awlen_q} + 9'd1;

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= 32'd0;
      awlen_q <= 8'd0;
      rem_q   <= 16'd0;
      beat_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= {cmd_addr[31:2], 2'b00};
              rem_q   <= cmd_len;
              awlen_q <= burst_awlen({cmd_addr[11:2], 2'b00}, cmd_len);
            end
          end
        end
        S_AW: begin
          if (awready) beat_q <= 8'd0;
        end
        S_W: begin
          if (s_valid && wready) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) begin
              // 32-bit add wraps modulo 2^32 past 0xFFFF_FFFC
              addr_q <= addr_q + {21'd0, beats, 2'b00};
              rem_q  <= rem_q - {7'd0, beats};
            end
          end
        end
        S_B: begin
          if (bvalid) begin
            if (rem_q == 16'd0) done_q  <= 1'b1;
            else                awlen_q <= burst_awlen(addr_q[11:0], rem_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (cmd_valid && (cmd_len != 16'd0)) state_nx = S_AW;
      S_AW:   if (awready) state_nx = S_W;
      S_W:    if (s_valid && wready && last_beat) state_nx = S_B;
      S_B:    if (bvalid) state_nx = (rem_q == 16'd0) ? S_IDLE : S_AW;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode; W is a combinational pass-through of the source
  always_comb begin
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    s_ready   = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_AW:   awvalid   = 1'b1;
      S_W: begin
        wvalid  = s_valid;
        s_ready = wready;
        wlast   = last_beat;
      end
      S_B:    bready    = 1'b1;
      default: ;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign done    = done_q;
  assign awaddr  = addr_q;
  assign awlen   = awlen_q;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign wdata   = s_data;
  assign wstrb   = 4'hF;

`ifdef AXI4_WR_BRESP_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state == S_IDLE) && cmd_valid) begin
      err <= 1'b0;
    end else if ((state == S_B) && bvalid && (bresp != 2'b00)) begin
      err <= 1'b1;
    end
  end
  assign unused_bits = &{1'b0, cmd_addr[1:0]};
`else
  assign unused_bits = &{1'b0, cmd_addr[1:0], bresp};
`endif

endmodule

// File: tb/tb_axi4_burst_wr_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_burst_wr_master
//   Randomized bench for axi4_burst_wr_master. A transaction-level model turns
//   each accepted command into the list of bursts it must produce (plain
//   min/boundary arithmetic) and tracks which channel is due; one negedge
//   process compares every DUT output against it each cycle. Directed cases
//   pin the model with literal burst addresses/lengths.
// -----------------------------------------------------------------------------
module tb_axi4_burst_wr_master;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = 32'd0;
  logic [15:0] cmd_len = 16'd0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        busy;
  logic        done;
`ifdef AXI4_WR_BRESP_CHK_EN
  logic        err;
`endif

  axi4_burst_wr_master #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .busy(busy), .done(done)
`ifdef AXI4_WR_BRESP_CHK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // stimulus knobs (percent ready/valid) and bresp mode: 0 OKAY, 1 random, 2 SLVERR on 2nd B
  int pa = 100, pw = 100, ps = 100, pb = 100, bresp_mode = 0;

  // model state
  logic [31:0] q_addr[$];
  int          q_len[$];
  bit          m_active = 0, m_await_b = 0, m_done_flag = 0, m_err = 0;
  int          w_left = 0, src_idx = 0, cmd_no = 0, b_hs_cnt = 0, cmd_beats = 0, dut_done_cnt = 0;
  logic [31:0] aw_log_addr[$];
  int          aw_log_len[$];
  int          wlast_log[$];

  function automatic logic [31:0] word(input int c, input int i);
    return {16'(c) ^ 16'hC0DE, 16'(i)};
  endfunction

  // Expected burst list from the splitting rules
  task automatic build_bursts(input logic [31:0] a_in, input int len);
    logic [31:0] a;
    int r, b, room;
    a = {a_in[31:2], 2'b00};
    r = len;
    while (r > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      b = r;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      q_addr.push_back(a);
      q_len.push_back(b);
      a = a + 32'(b * 4);
      r = r - b;
    end
  endtask

  // Random slave/source behaviour, driven just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      awready = ($urandom_range(99) < pa);
      wready  = ($urandom_range(99) < pw);
      s_valid = ($urandom_range(99) < ps);
      bvalid  = ($urandom_range(99) < pb);
      s_data  = word(cmd_no, src_idx);
      case (bresp_mode)
        1:       bresp = 2'($urandom_range(3));
        2:       bresp = (b_hs_cnt == 1) ? 2'b10 : 2'b00;
        default: bresp = 2'b00;
      endcase
    end
  end

  // Per-cycle compare against the model, then advance the model by the
  // handshakes that the coming rising edge will complete
  always @(negedge clk) begin
    bit exp_aw, exp_w;
    if (rst) begin
      q_addr.delete();
      q_len.delete();
      m_active = 0; m_await_b = 0; m_done_flag = 0; m_err = 0;
      w_left = 0; src_idx = 0;
    end else begin
      exp_aw = m_active && (w_left == 0) && !m_await_b;
      exp_w  = (w_left > 0);
      check("cmd_ready", cmd_ready, !m_active);
      check("busy", busy, m_active);
      check("awvalid", awvalid, exp_aw);
      check("wvalid", wvalid, exp_w ? s_valid : 1'b0);
      check("s_ready", s_ready, exp_w ? wready : 1'b0);
      check("bready", bready, m_await_b);
      check("done", done, m_done_flag);
      check("awsize", awsize, 3'd2);
      check("awburst", awburst, 2'b01);
      check("wstrb", wstrb, 4'hF);
`ifdef AXI4_WR_BRESP_CHK_EN
      check("err", err, m_err);
`endif
      if (exp_aw) begin
        if (q_addr.size() > 0) begin
          check("awaddr", awaddr, q_addr[0]);
          check("awlen", awlen, 32'(q_len[0] - 1));
        end else fail_now("model_burst_queue");
      end
      if (exp_w) begin
        check("wlast", wlast, (w_left == 1));
        if (s_valid) check("wdata", wdata, word(cmd_no, src_idx));
      end
      if (done) dut_done_cnt++;
      m_done_flag = 0;

      if (!m_active) begin
        if (cmd_valid) begin
          cmd_no++;
          src_idx = 0; m_err = 0; b_hs_cnt = 0; cmd_beats = 0; dut_done_cnt = 0;
          aw_log_addr.delete(); aw_log_len.delete(); wlast_log.delete();
          if (cmd_len == 16'd0) m_done_flag = 1;
          else begin
            build_bursts(cmd_addr, int'(cmd_len));
            m_active = 1;
          end
        end
      end else if (exp_aw && awready) begin
        aw_log_addr.push_back(awaddr);
        aw_log_len.push_back(int'(awlen));
        if (q_len.size() > 0) begin
          w_left = q_len.pop_front();
          void'(q_addr.pop_front());
        end
      end else if (exp_w && s_valid && wready) begin
        cmd_beats++;
        if (wlast) wlast_log.push_back(cmd_beats);
        src_idx++;
        w_left--;
        if (w_left == 0) m_await_b = 1;
      end else if (m_await_b && bvalid) begin
        m_await_b = 0;
        b_hs_cnt++;
        if (bresp != 2'b00) m_err = 1;
        if (q_len.size() == 0) begin
          m_active = 0;
          m_done_flag = 1;
        end
      end
    end
  end

  task automatic issue_cmd(input logic [31:0] a, input logic [15:0] l);
    int t;
    @(posedge clk);
    #1;
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (cmd_ready) break;
      t++;
      if (t > 200) begin fail_now("cmd_accept"); break; end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr = $urandom;
    cmd_len = 16'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      t++;
      if (t > 6000) begin fail_now("wait_done"); break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [15:0] l);
    issue_cmd(a, l);
    wait_done();
  endtask

  task automatic check_aw(input string name, input int i, input logic [31:0] a, input int l);
    if (i < aw_log_addr.size()) begin
      check({name, "_addr"}, aw_log_addr[i], a);
      check({name, "_len"}, 32'(aw_log_len[i]), 32'(l));
    end else fail_now({name, "_missing"});
  endtask

  task automatic check_wlast(input string name, input int i, input int beat);
    if (i < wlast_log.size()) check(name, 32'(wlast_log[i]), 32'(beat));
    else fail_now({name, "_missing"});
  endtask

  initial begin
    logic [31:0] a;
    int t;
    // reset state
    #12;
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_awlen", awlen, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    #10 rst = 1'b0;

    // basic split
    run_cmd(32'h0000_1000, 16'd40);
    check("basic_nbursts", 32'(aw_log_addr.size()), 32'd3);
    check_aw("basic_b0", 0, 32'h0000_1000, 15);
    check_aw("basic_b1", 1, 32'h0000_1040, 15);
    check_aw("basic_b2", 2, 32'h0000_1080, 7);
    check_wlast("basic_wlast0", 0, 16);
    check_wlast("basic_wlast1", 1, 32);
    check_wlast("basic_wlast2", 2, 40);
    check("basic_done_cnt", 32'(dut_done_cnt), 32'd1);

    // 4 KB crossing
    run_cmd(32'h0000_0FF8, 16'd8);
    check("x4k_nbursts", 32'(aw_log_addr.size()), 32'd2);
    check_aw("x4k_b0", 0, 32'h0000_0FF8, 1);
    check_aw("x4k_b1", 1, 32'h0000_1000, 5);

    // address wrap, and ignored low address bits
    run_cmd(32'hFFFF_FFF0, 16'd8);
    check_aw("wrap_b0", 0, 32'hFFFF_FFF0, 3);
    check_aw("wrap_b1", 1, 32'h0000_0000, 3);
    run_cmd(32'h0000_2003, 16'd2);
    check_aw("unal_b0", 0, 32'h0000_2000, 1);

    // zero length
    run_cmd(32'h0000_4000, 16'd0);
    check("zero_nbursts", 32'(aw_log_addr.size()), 32'd0);
    check("zero_done_cnt", 32'(dut_done_cnt), 32'd1);

`ifdef AXI4_WR_BRESP_CHK_EN
    // error response on the second B
    bresp_mode = 2;
    run_cmd(32'h0000_3000, 16'd32);
    check("err_after_done", err, 1'b1);
    bresp_mode = 0;
    issue_cmd(32'h0000_3100, 16'd4);
    @(negedge clk);
    check("err_cleared", err, 1'b0);
    wait_done();
`endif

    // randomized backpressure
    pa = 50; pw = 50; ps = 50; pb = 50; bresp_mode = 1;
    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      if ($urandom_range(1) == 1) a[11:0] = 12'hF00 | 12'($urandom_range(255));
      run_cmd(a, 16'($urandom_range(70)));
    end
    pa = 100; pw = 100; ps = 100; pb = 100; bresp_mode = 0;

    // reset mid-burst
    issue_cmd(32'h0000_2000, 16'd20);
    t = 0;
    while (cmd_beats < 4) begin
      @(negedge clk);
      t++;
      if (t > 200) begin fail_now("reach_beat5"); break; end
    end
    check("pre_rst_wvalid", wvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_awvalid", awvalid, 1'b0);
    check("arst_wvalid", wvalid, 1'b0);
    check("arst_bready", bready, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_cmd_ready", cmd_ready, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    run_cmd(32'h0000_2000, 16'd20);
    check_aw("post_rst_b0", 0, 32'h0000_2000, 15);
    check_aw("post_rst_b1", 1, 32'h0000_2040, 3);
    check_wlast("post_rst_wlast1", 1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
